// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   // Conventional requester slot assignment
   localparam int REQ_ALU  = 0;
   localparam int REQ_MEM  = 1;
   localparam int REQ_LINK = 2;

   // One holding slot per requester
   typedef struct packed {
      logic              full;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } slot_t;

   // Decode a register address into a one-hot register mask
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
      logic [NUM_REGS-1:0] m;
      m    = '0;
      m[a] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational N-way arbiter: round-robin from rr_ptr, or fixed priority
// (index 0 highest) when rr_mode is low. The pointer register lives in the parent.
module wb_rr_arbiter #(
   parameter int N_REQ = 3,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   input  logic             rr_mode,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   // Walk candidates in priority order and grant the first requesting one
   always_comb begin
      logic [IDX_W-1:0] cand;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = rr_mode ? IDX_W'((int'(rr_ptr) + k) % N_REQ) : IDX_W'(k);
         for (int i = 0; i < N_REQ; i++) begin
            if (!grant_valid && req[i] && (IDX_W'(i) == cand)) begin
               grant[i]    = 1'b1;
               grant_idx   = IDX_W'(i);
               grant_valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing the single register-file write port between
// N_REQ requesters, each with a one-entry holding slot.
// Optional macro WB_BYPASS_EN adds two combinational bypass read ports that
// expose the write currently on the port before the register file commits it.
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int N_REQ      = 3,
   parameter int RR_MODE    = 1,
   parameter int ZERO_GUARD = 1
) (
   input  logic                      clk,
   input  logic                      res,
   input  logic [N_REQ-1:0]          in_valid,
   output logic [N_REQ-1:0]          in_ready,
   input  logic [ADDR_W*N_REQ-1:0]   in_addr,
   input  logic [DATA_W*N_REQ-1:0]   in_data,
   input  logic                      hold,
   input  logic                      flush,
   output logic                      wen,
   output logic [ADDR_W-1:0]         wadd,
   output logic [DATA_W-1:0]         wdi,
   output logic [NUM_REGS-1:0]       busy
`ifdef WB_BYPASS_EN
   ,
   input  logic [ADDR_W-1:0]         byp_addr1,
   input  logic [ADDR_W-1:0]         byp_addr2,
   output logic                      byp_hit1,
   output logic                      byp_hit2,
   output logic [DATA_W-1:0]         byp_data1,
   output logic [DATA_W-1:0]         byp_data2
`endif
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]  slot_full;
   logic [ADDR_W-1:0] slot_addr [N_REQ];
   logic [DATA_W-1:0] slot_data [N_REQ];
   slot_t             slots     [N_REQ];
   slot_t             win;

   logic [N_REQ-1:0]  req;
   logic [N_REQ-1:0]  grant;
   logic [N_REQ-1:0]  accept;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  grant_idx;
   logic [IDX_W-1:0]  next_ptr;
   logic              grant_valid;

   // Gather slot state into records and select the granted slot
   always_comb begin
      win = '0;
      for (int i = 0; i < N_REQ; i++) begin
         slots[i] = '{full: slot_full[i], addr: slot_addr[i], data: slot_data[i]};
         if (grant[i]) win = slots[i];
      end
   end

   // hold and flush both block every grant
   assign req = slot_full & {N_REQ{!(hold || flush)}};

   wb_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
      .req         (req),
      .rr_ptr      (rr_ptr),
      .rr_mode     (RR_MODE != 0),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // A slot can refill in the same cycle it drains, so the port sustains 1 write/cycle
   assign in_ready = {N_REQ{!flush}} & (~slot_full | grant);
   assign accept   = in_valid & in_ready;
   assign next_ptr = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

   // Slot occupancy: flush empties everything, an accept wins over a drain
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         slot_full <= '0;
      end else if (flush) begin
         slot_full <= '0;
      end else begin
         slot_full <= accept | (slot_full & ~grant);
      end
   end

   // Slot payload capture; contents are only meaningful while the slot is full
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (accept[i]) begin
            slot_addr[i] <= in_addr[ADDR_W*i +: ADDR_W];
            slot_data[i] <= in_data[DATA_W*i +: DATA_W];
         end
      end
   end

   // Round-robin pointer advances past the winner; unchanged without a grant
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         rr_ptr <= '0;
      end else if (grant_valid && (RR_MODE != 0)) begin
         rr_ptr <= next_ptr;
      end
   end

   // Registered write port; register 0 writes are dropped but still update addr/data
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         wen  <= 1'b0;
         wadd <= '0;
         wdi  <= '0;
      end else if (grant_valid && win.full) begin
         wen  <= !((ZERO_GUARD != 0) && (win.addr == '0));
         wadd <= win.addr;
         wdi  <= win.data;
      end else begin
         wen  <= 1'b0;
      end
   end

   // Pending-write bitmap from queued slots plus the write on the port
   always_comb begin
      busy = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (slot_full[i]) busy = busy | reg_onehot(slot_addr[i]);
      end
      if (wen) busy = busy | reg_onehot(wadd);
      if (ZERO_GUARD != 0) busy[0] = 1'b0;
   end

`ifdef WB_BYPASS_EN
   // Forward the in-flight write to readers that sample before the commit edge
   always_comb begin
      byp_hit1  = wen && (wadd == byp_addr1) && (byp_addr1 != '0);
      byp_hit2  = wen && (wadd == byp_addr2) && (byp_addr2 != '0);
      byp_data1 = byp_hit1 ? wdi : '0;
      byp_data2 = byp_hit2 ? wdi : '0;
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (round-robin instance plus a
// fixed-priority instance); bypass ports exercised when WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        res;
   logic [2:0]  in_valid;
   logic [2:0]  in_ready;
   logic [14:0] in_addr;
   logic [95:0] in_data;
   logic        hold, flush, wen;
   logic [4:0]  wadd;
   logic [31:0] wdi, busy;
`ifdef WB_BYPASS_EN
   logic [4:0]  byp_addr1, byp_addr2;
   logic        byp_hit1, byp_hit2;
   logic [31:0] byp_data1, byp_data2;
`endif

   logic [2:0]  f_valid, f_ready;
   logic [14:0] f_addr;
   logic [95:0] f_data;
   logic        f_hold, f_flush, f_wen;
   logic [4:0]  f_wadd;
   logic [31:0] f_wdi, f_busy;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.N_REQ(3), .RR_MODE(1), .ZERO_GUARD(1)) dut (
      .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .hold(hold), .flush(flush),
      .wen(wen), .wadd(wadd), .wdi(wdi), .busy(busy)
`ifdef WB_BYPASS_EN
      , .byp_addr1(byp_addr1), .byp_addr2(byp_addr2), .byp_hit1(byp_hit1),
      .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
   );

   regfile_wb_arbiter #(.N_REQ(3), .RR_MODE(0), .ZERO_GUARD(1)) dut_fp (
      .clk(clk), .res(res), .in_valid(f_valid), .in_ready(f_ready),
      .in_addr(f_addr), .in_data(f_data), .hold(f_hold), .flush(f_flush),
      .wen(f_wen), .wadd(f_wadd), .wdi(f_wdi), .busy(f_busy)
`ifdef WB_BYPASS_EN
      , .byp_addr1(5'd0), .byp_addr2(5'd0), .byp_hit1(), .byp_hit2(),
      .byp_data1(), .byp_data2()
`endif
   );

   // Reference model: pending writes per requester plus the write on the port
   bit          m_full [N];
   logic [4:0]  m_addr [N];
   logic [31:0] m_data [N];
   int          m_ptr;
   bit          m_wen;
   logic [4:0]  m_wadd;
   logic [31:0] m_wdi;

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_full[i] = 0; m_addr[i] = '0; m_data[i] = '0;
      end
      m_ptr = 0; m_wen = 0; m_wadd = '0; m_wdi = '0;
   endtask

   function automatic int m_winner();
      if (hold || flush) return -1;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (m_full[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [2:0] m_ready();
      logic [2:0] r;
      int w;
      w = m_winner();
      for (int i = 0; i < N; i++) r[i] = !flush && (!m_full[i] || w == i);
      return r;
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] b;
      b = '0;
      for (int i = 0; i < N; i++) if (m_full[i]) b[m_addr[i]] = 1'b1;
      if (m_wen) b[m_wadd] = 1'b1;
      b[0] = 1'b0;
      return b;
   endfunction

   // Advance one clock on both the model and the DUT, ending 1 time unit after the edge
   task automatic tick();
      int w;
      logic [2:0] acc;
      w   = m_winner();
      acc = in_valid & m_ready();
      @(posedge clk);
      if (w >= 0) begin
         m_wen  = (m_addr[w] != 5'd0);
         m_wadd = m_addr[w];
         m_wdi  = m_data[w];
         m_ptr  = (w + 1) % N;
      end else begin
         m_wen = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (flush) m_full[i] = 0;
         else if (acc[i]) begin
            m_full[i] = 1;
            m_addr[i] = in_addr[5*i +: 5];
            m_data[i] = in_data[32*i +: 32];
         end else if (w == i) m_full[i] = 0;
      end
      #1;
   endtask

   task automatic drain();
      in_valid = '0; hold = 0; flush = 0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      res = 1'b0;
      #3;
      n_total++; if (wen !== 1'b0) $display("FAIL reset_wen: got %0b want 0", wen); else n_pass++;
      n_total++; if (wadd !== 5'd0) $display("FAIL reset_wadd: got %0d want 0", wadd); else n_pass++;
      n_total++; if (wdi !== 32'd0) $display("FAIL reset_wdi: got %h want 0", wdi); else n_pass++;
      n_total++; if (busy !== 32'd0) $display("FAIL reset_busy: got %h want 0", busy); else n_pass++;
      n_total++; if (in_ready !== 3'b111) $display("FAIL reset_ready: got %b want 111", in_ready); else n_pass++;
      @(negedge clk);
      res = 1'b1;
      m_reset();
   endtask

   task automatic test_single();
      in_valid = 3'b001;
      in_addr[4:0]  = 5'd5;
      in_data[31:0] = 32'hDEADBEEF;
      #1;
      n_total++; if (in_ready[0] !== 1'b1) $display("FAIL single_ready: got %b want 1", in_ready[0]); else n_pass++;
      tick();
      n_total++; if (wen !== 1'b0) $display("FAIL single_wen_e0: got %0b want 0", wen); else n_pass++;
      n_total++; if (busy !== 32'h20) $display("FAIL single_busy_e0: got %h want 00000020", busy); else n_pass++;
      in_valid = 3'b000;
      tick();
      n_total++; if (wen !== 1'b1) $display("FAIL single_wen_e1: got %0b want 1", wen); else n_pass++;
      n_total++; if (wadd !== 5'd5) $display("FAIL single_wadd: got %0d want 5", wadd); else n_pass++;
      n_total++; if (wdi !== 32'hDEADBEEF) $display("FAIL single_wdi: got %h want deadbeef", wdi); else n_pass++;
      n_total++; if (busy !== 32'h20) $display("FAIL single_busy_e1: got %h want 00000020", busy); else n_pass++;
      tick();
      n_total++; if (wen !== 1'b0) $display("FAIL single_wen_e2: got %0b want 0", wen); else n_pass++;
      n_total++; if (busy !== 32'h0) $display("FAIL single_busy_e2: got %h want 0", busy); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [4:0] prev;
      prev = '0;
      in_valid = 3'b111;
      in_addr  = {5'd3, 5'd2, 5'd1};
      for (int c = 0; c < 12; c++) begin
         in_data = {$urandom, $urandom, $urandom};
         #1;
         n_total++; if (in_ready !== m_ready()) $display("FAIL rr_ready[%0d]: got %b want %b", c, in_ready, m_ready()); else n_pass++;
         tick();
         n_total++; if (wen !== m_wen || wadd !== m_wadd || wdi !== m_wdi)
            $display("FAIL rr_port[%0d]: got %0b/%0d/%h want %0b/%0d/%h", c, wen, wadd, wdi, m_wen, m_wadd, m_wdi);
         else n_pass++;
         if (c >= 1) begin
            n_total++; if (wen !== 1'b1) $display("FAIL rr_wen_steady[%0d]: got %0b want 1", c, wen); else n_pass++;
         end
         if (c >= 2) begin
            n_total++; if (wadd !== (prev % 3) + 1) $display("FAIL rr_order[%0d]: got %0d want %0d", c, wadd, (prev % 3) + 1); else n_pass++;
         end
         prev = wadd;
      end
      drain();
   endtask

   task automatic test_zero_guard();
      in_valid = 3'b001;
      in_addr[4:0]  = 5'd0;
      in_data[31:0] = 32'h55;
      #1;
      n_total++; if (in_ready[0] !== 1'b1) $display("FAIL zero_ready: got %b want 1", in_ready[0]); else n_pass++;
      tick();
      n_total++; if (busy[0] !== 1'b0) $display("FAIL zero_busy0: got %b want 0", busy[0]); else n_pass++;
      in_valid = 3'b000;
      repeat (2) begin
         tick();
         n_total++; if (wen !== 1'b0) $display("FAIL zero_wen: got %0b want 0", wen); else n_pass++;
         n_total++; if (busy[0] !== 1'b0) $display("FAIL zero_busy0_late: got %b want 0", busy[0]); else n_pass++;
      end
      in_valid = 3'b001;
      in_addr[4:0]  = 5'd7;
      in_data[31:0] = 32'hA5A5_0007;
      tick();
      in_valid = 3'b000;
      tick();
      n_total++; if (wen !== 1'b1 || wadd !== 5'd7 || wdi !== 32'hA5A5_0007)
         $display("FAIL zero_next_write: got %0b/%0d/%h want 1/7/a5a50007", wen, wadd, wdi);
      else n_pass++;
      drain();
   endtask

   task automatic test_hold_flush();
      hold = 1; in_valid = 3'b111;
      in_addr = {5'd6, 5'd5, 5'd4};
      in_data = {32'h6, 32'h5, 32'h4};
      #1;
      n_total++; if (in_ready !== 3'b111) $display("FAIL hold_ready: got %b want 111", in_ready); else n_pass++;
      tick();
      in_valid = 3'b000;
      repeat (3) begin
         tick();
         n_total++; if (wen !== 1'b0) $display("FAIL hold_wen: got %0b want 0", wen); else n_pass++;
         n_total++; if (busy !== 32'h70) $display("FAIL hold_busy: got %h want 00000070", busy); else n_pass++;
      end
      flush = 1; in_valid = 3'b111;
      #1;
      n_total++; if (in_ready !== 3'b000) $display("FAIL flush_ready: got %b want 000", in_ready); else n_pass++;
      tick();
      flush = 0; hold = 0; in_valid = 3'b000;
      n_total++; if (busy !== 32'h0) $display("FAIL flush_busy: got %h want 0", busy); else n_pass++;
      repeat (3) begin
         tick();
         n_total++; if (wen !== 1'b0) $display("FAIL flush_wen: got %0b want 0", wen); else n_pass++;
      end
      // Async reset in the middle of traffic
      in_valid = 3'b111;
      in_addr  = {5'd13, 5'd12, 5'd11};
      tick();
      tick();
      n_total++; if (wen !== 1'b1) $display("FAIL async_pre_wen: got %0b want 1", wen); else n_pass++;
      #2 res = 1'b0;
      #1;
      n_total++; if (wen !== 1'b0) $display("FAIL async_wen: got %0b want 0", wen); else n_pass++;
      n_total++; if (busy !== 32'h0) $display("FAIL async_busy: got %h want 0", busy); else n_pass++;
      in_valid = 3'b000;
      m_reset();
      @(negedge clk);
      res = 1'b1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 80; c++) begin
         in_valid = 3'($urandom);
         in_addr  = 15'($urandom);
         in_data  = {$urandom, $urandom, $urandom};
         hold     = ($urandom_range(0, 5) == 0);
         flush    = ($urandom_range(0, 11) == 0);
         #1;
         n_total++; if (in_ready !== m_ready()) $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, m_ready()); else n_pass++;
         tick();
         n_total++; if (wen !== m_wen || wadd !== m_wadd || wdi !== m_wdi)
            $display("FAIL rand_port[%0d]: got %0b/%0d/%h want %0b/%0d/%h", c, wen, wadd, wdi, m_wen, m_wadd, m_wdi);
         else n_pass++;
         n_total++; if (busy !== m_busy()) $display("FAIL rand_busy[%0d]: got %h want %h", c, busy, m_busy()); else n_pass++;
      end
      drain();
   endtask

   task automatic test_fixed_priority();
      f_valid = 3'b101;
      f_addr  = {5'd12, 5'd0, 5'd10};
      for (int c = 0; c < 10; c++) begin
         f_data = {32'hC0DE_0000 + 32'(c), 32'h0, 32'hA000_0000 + 32'(c)};
         #1;
         if (c == 0) begin
            n_total++; if (f_ready !== 3'b111) $display("FAIL fp_ready_first: got %b want 111", f_ready); else n_pass++;
         end else begin
            n_total++; if (f_ready[2] !== 1'b0 || f_ready[0] !== 1'b1)
               $display("FAIL fp_ready[%0d]: got %b want 0x1", c, f_ready);
            else n_pass++;
         end
         @(posedge clk); #1;
         if (c >= 1) begin
            n_total++; if (f_wen !== 1'b1 || f_wadd !== 5'd10 || f_wdi !== 32'hA000_0000 + 32'(c - 1))
               $display("FAIL fp_port[%0d]: got %0b/%0d/%h want 1/10/%h", c, f_wen, f_wadd, f_wdi, 32'hA000_0000 + 32'(c - 1));
            else n_pass++;
         end
      end
      f_valid = 3'b000;
   endtask

`ifdef WB_BYPASS_EN
   task automatic test_bypass();
      in_valid = 3'b001;
      in_addr[4:0]  = 5'd9;
      in_data[31:0] = 32'h1234;
      tick();
      in_valid = 3'b000;
      tick();
      byp_addr1 = 5'd9;
      byp_addr2 = 5'd0;
      #1;
      n_total++; if (byp_hit1 !== 1'b1) $display("FAIL byp_hit1: got %0b want 1", byp_hit1); else n_pass++;
      n_total++; if (byp_data1 !== 32'h1234) $display("FAIL byp_data1: got %h want 00001234", byp_data1); else n_pass++;
      n_total++; if (byp_hit2 !== 1'b0) $display("FAIL byp_hit2: got %0b want 0", byp_hit2); else n_pass++;
      n_total++; if (byp_data2 !== 32'h0) $display("FAIL byp_data2: got %h want 0", byp_data2); else n_pass++;
      drain();
   endtask
`endif

   initial begin
      in_valid = '0; in_addr = '0; in_data = '0; hold = 0; flush = 0;
      f_valid = '0; f_addr = '0; f_data = '0; f_hold = 0; f_flush = 0;
`ifdef WB_BYPASS_EN
      byp_addr1 = '0; byp_addr2 = '0;
`endif
      m_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_zero_guard();
      test_hold_flush();
      test_random();
      test_fixed_priority();
`ifdef WB_BYPASS_EN
      test_bypass();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
